// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters
// (req0 = execute stage, req1 = address/branch calc). Optional macro: ALU_PERF_CNT_EN.
module alu_arbiter #(
    parameter int DATA_WIDTH   = 16,
    parameter int FLAG_WIDTH   = 3,
    parameter int CNT_WIDTH    = 16,
    parameter int OPCODE_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [DATA_WIDTH-1:0]   req0_a,
    input  logic [DATA_WIDTH-1:0]   req0_b,
    input  logic                    req0_cin,
    input  logic [OPCODE_WIDTH-1:0] req0_opcode,
    input  logic                    req0_mode,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [DATA_WIDTH-1:0]   req1_a,
    input  logic [DATA_WIDTH-1:0]   req1_b,
    input  logic                    req1_cin,
    input  logic [OPCODE_WIDTH-1:0] req1_opcode,
    input  logic                    req1_mode,
    output logic                    rsp0_valid,
    input  logic                    rsp0_ready,
    output logic                    rsp1_valid,
    input  logic                    rsp1_ready,
    output logic [DATA_WIDTH-1:0]   rsp_result,
    output logic [FLAG_WIDTH-1:0]   rsp_flag,
    output logic [DATA_WIDTH-1:0]   alu_in_a,
    output logic [DATA_WIDTH-1:0]   alu_in_b,
    output logic                    alu_cin,
    output logic [OPCODE_WIDTH-1:0] alu_opcode,
    output logic                    alu_mode,
    input  logic [DATA_WIDTH-1:0]   alu_out,
    input  logic [FLAG_WIDTH-1:0]   alu_out_flag
`ifdef ALU_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]    perf_cnt0,
    output logic [CNT_WIDTH-1:0]    perf_cnt1
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                  state, state_nxt;
    logic                    last_grant;
    logic                    grant_id;
    logic                    grant_en;
    logic                    grant_nxt;
    logic [DATA_WIDTH-1:0]   op_a, op_b;
    logic                    op_cin, op_mode;
    logic [OPCODE_WIDTH-1:0] op_opcode;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        grant_en   = 1'b0;
        grant_nxt  = last_grant;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (state)
            IDLE: begin
                // Contention goes to whoever was not granted last; a lone request always wins.
                if (!rst && (req0_valid || req1_valid)) begin
                    grant_en   = 1'b1;
                    grant_nxt  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
                    req0_ready = ~grant_nxt;
                    req1_ready = grant_nxt;
                    state_nxt  = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                rsp0_valid = ~grant_id;
                rsp1_valid = grant_id;
                if (grant_id ? rsp1_ready : rsp0_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            op_cin     <= 1'b0;
            op_opcode  <= '0;
            op_mode    <= 1'b0;
            rsp_result <= '0;
            rsp_flag   <= '0;
        end else begin
            if (grant_en) begin
                last_grant <= grant_nxt;
                grant_id   <= grant_nxt;
                op_a       <= grant_nxt ? req1_a      : req0_a;
                op_b       <= grant_nxt ? req1_b      : req0_b;
                op_cin     <= grant_nxt ? req1_cin    : req0_cin;
                op_opcode  <= grant_nxt ? req1_opcode : req0_opcode;
                op_mode    <= grant_nxt ? req1_mode   : req0_mode;
            end
            if (state == EXEC) begin
                rsp_result <= alu_out;
                rsp_flag   <= alu_out_flag;
            end
        end
    end

    assign alu_in_a   = op_a;
    assign alu_in_b   = op_b;
    assign alu_cin    = op_cin;
    assign alu_opcode = op_opcode;
    assign alu_mode   = op_mode;

`ifdef ALU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt0 <= '0;
            perf_cnt1 <= '0;
        end else begin
            if (rsp0_valid && rsp0_ready && perf_cnt0 != '1) perf_cnt0 <= perf_cnt0 + 1'b1;
            if (rsp1_valid && rsp1_ready && perf_cnt1 != '1) perf_cnt1 <= perf_cnt1 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter with a transaction-level model
// and a behavioural ALU on the alu_* pins.
module tb_alu_arbiter;
    localparam int DW = 16;
    localparam int FW = 3;
    localparam int CW = 16;
    localparam int OW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          v[2], rr[2];
    logic [DW-1:0] r_a[2], r_b[2];
    logic          r_cin[2], r_mode[2];
    logic [OW-1:0] r_op[2];
    logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp_result, alu_in_a, alu_in_b, alu_out;
    logic [FW-1:0] rsp_flag, alu_out_flag;
    logic          alu_cin, alu_mode;
    logic [OW-1:0] alu_opcode;
`ifdef ALU_PERF_CNT_EN
    logic [CW-1:0] perf_cnt0, perf_cnt1;
`endif

    alu_arbiter #(.DATA_WIDTH(DW), .FLAG_WIDTH(FW), .CNT_WIDTH(CW), .OPCODE_WIDTH(OW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v[0]), .req0_ready(req0_ready), .req0_a(r_a[0]), .req0_b(r_b[0]),
        .req0_cin(r_cin[0]), .req0_opcode(r_op[0]), .req0_mode(r_mode[0]),
        .req1_valid(v[1]), .req1_ready(req1_ready), .req1_a(r_a[1]), .req1_b(r_b[1]),
        .req1_cin(r_cin[1]), .req1_opcode(r_op[1]), .req1_mode(r_mode[1]),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rr[0]), .rsp1_valid(rsp1_valid), .rsp1_ready(rr[1]),
        .rsp_result(rsp_result), .rsp_flag(rsp_flag),
        .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_cin(alu_cin),
        .alu_opcode(alu_opcode), .alu_mode(alu_mode),
        .alu_out(alu_out), .alu_out_flag(alu_out_flag)
`ifdef ALU_PERF_CNT_EN
        , .perf_cnt0(perf_cnt0), .perf_cnt1(perf_cnt1)
`endif
    );

    // Stand-in ALU: arith add/sub with {0,carry,zero}; logic ops with {neg,parity,zero}.
    function automatic logic [DW+FW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                input logic cin, input logic [OW-1:0] op, input logic mode);
        logic [DW:0]   s;
        logic [DW-1:0] r;
        if (mode) begin
            s = op[0] ? ({1'b0, a} + {1'b0, ~b} + DW'(cin)) : ({1'b0, a} + {1'b0, b} + DW'(cin));
            return {1'b0, s[DW], s[DW-1:0] == '0, s[DW-1:0]};
        end
        case (op[1:0])
            2'd0:    r = a & b;
            2'd1:    r = a | b;
            2'd2:    r = a ^ b;
            default: r = ~a;
        endcase
        return {r[DW-1], ^r, r == '0, r};
    endfunction

    assign {alu_out_flag, alu_out} = alu_fn(alu_in_a, alu_in_b, alu_cin, alu_opcode, alu_mode);

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: at most one op in flight, tracked by its age in cycles since acceptance.
    logic          m_busy, m_id, m_last;
    int            m_age;
    logic [DW-1:0] m_a, m_b, m_res;
    logic          m_cin, m_mode;
    logic [OW-1:0] m_op;
    logic [FW-1:0] m_flag;
    int            m_cnt[2];
    logic          d_rdy[2];

    task automatic model_reset();
        m_busy = 0; m_id = 0; m_last = 1; m_age = 0;
        m_a = '0; m_b = '0; m_cin = 0; m_op = '0; m_mode = 0;
        m_res = '0; m_flag = '0;
        m_cnt[0] = 0; m_cnt[1] = 0;
    endtask

    task automatic issue(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic cin, input logic [OW-1:0] op, input logic mode);
        r_a[id] = a; r_b[id] = b; r_cin[id] = cin; r_op[id] = op; r_mode[id] = mode; v[id] = 1;
    endtask

    task automatic run_cycle();
        logic e0, e1, done;
        @(negedge clk);
        e0   = !rst && !m_busy && v[0] && (!v[1] || m_last);
        e1   = !rst && !m_busy && v[1] && (!v[0] || !m_last);
        done = m_busy && m_age >= 2;
        d_rdy[0] = req0_ready;
        d_rdy[1] = req1_ready;
        check_val("req0_ready", req0_ready, e0);
        check_val("req1_ready", req1_ready, e1);
        check_val("rsp0_valid", rsp0_valid, done && !m_id);
        check_val("rsp1_valid", rsp1_valid, done && m_id);
        check_val("rsp_result", rsp_result, m_res);
        check_val("rsp_flag", rsp_flag, m_flag);
        check_val("alu_in_a", alu_in_a, m_a);
        check_val("alu_in_b", alu_in_b, m_b);
        check_val("alu_ctl", {alu_cin, alu_mode, alu_opcode}, {m_cin, m_mode, m_op});
`ifdef ALU_PERF_CNT_EN
        check_val("perf_cnt0", perf_cnt0, m_cnt[0]);
        check_val("perf_cnt1", perf_cnt1, m_cnt[1]);
`endif
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else if (m_busy) begin
            if (m_age == 1) begin
                {m_flag, m_res} = alu_fn(m_a, m_b, m_cin, m_op, m_mode);
                m_age = 2;
            end else if (rr[m_id]) begin
                m_busy = 0;
                if (m_cnt[m_id] < (1 << CW) - 1) m_cnt[m_id]++;
            end
        end else if (e0 || e1) begin
            m_id = e1; m_last = e1; m_busy = 1; m_age = 1;
            m_a = r_a[m_id]; m_b = r_b[m_id]; m_cin = r_cin[m_id]; m_op = r_op[m_id]; m_mode = r_mode[m_id];
            v[m_id] = 0;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1; v[0] = 0; v[1] = 0;
        repeat (n) run_cycle();
        rst = 0;
    endtask

    task automatic rand_req(input int i);
        issue(i, DW'($urandom), DW'($urandom), 1'($urandom), OW'($urandom_range(0, 7)), 1'($urandom));
    endtask

    logic exp_g;

    initial begin
        rst = 1; rr[0] = 0; rr[1] = 0; v[0] = 0; v[1] = 0;
        for (int i = 0; i < 2; i++) begin
            r_a[i] = '0; r_b[i] = '0; r_cin[i] = 0; r_op[i] = '0; r_mode[i] = 0;
        end
        model_reset();
        @(posedge clk);
        #1;
        do_reset(2);

        // Continuous contention: first grant to req0, then strict alternation.
        rr[0] = 1; rr[1] = 1; exp_g = 0;
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < 2; i++) if (!v[i]) rand_req(i);
            run_cycle();
            if (d_rdy[0] || d_rdy[1]) begin
                check_val("contention_grant", d_rdy[1], exp_g);
                exp_g = ~exp_g;
            end
        end
        v[0] = 0; v[1] = 0;
        repeat (3) run_cycle();

        // Single ADD on req0: accept, EXEC, then response with 16'h8000.
        do_reset(1);
        rr[0] = 1;
        issue(0, 16'h7FFF, 16'h0001, 1'b0, 4'd0, 1'b1);
        run_cycle();
        check_val("add_ready", d_rdy[0], 1);
        run_cycle();
        check_val("add_rsp_valid", rsp0_valid, 1);
        check_val("add_result", rsp_result, 16'h8000);
        check_val("add_flag", rsp_flag, 3'b000);
        run_cycle();

        // AND on req1 with response stalled; req0 must wait for the handshake.
        rr[1] = 0;
        issue(1, 16'hF0F0, 16'h0FF0, 1'b0, 4'd0, 1'b0);
        run_cycle();
        rand_req(0);
        run_cycle();
        repeat (5) run_cycle();
        check_val("and_held_valid", rsp1_valid, 1);
        check_val("and_result", rsp_result, 16'h00F0);
        rr[1] = 1;
        run_cycle();
        run_cycle();
        check_val("waiting_req0_granted", d_rdy[0], 1);
        repeat (3) run_cycle();

        // Reset while EXEC: the in-flight op never responds.
        issue(0, 16'h1234, 16'h4321, 1'b1, 4'd1, 1'b1);
        run_cycle();
        rst = 1;
        run_cycle();
        rst = 0;
        check_val("post_rst_rsp0", rsp0_valid, 0);
        repeat (4) run_cycle();

        // Random traffic with backpressure and occasional request drops.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!v[i]) begin
                    if ($urandom_range(0, 2) == 0) rand_req(i);
                end else if ($urandom_range(0, 19) == 0) begin
                    v[i] = 0;
                end
                rr[i] = ($urandom_range(0, 3) != 0);
            end
            run_cycle();
        end

`ifdef ALU_PERF_CNT_EN
        do_reset(1);
        rr[0] = 1; rr[1] = 1;
        for (int k = 0; k < 5; k++) begin
            rand_req(k < 3 ? 0 : 1);
            repeat (3) run_cycle();
        end
        check_val("perf0_count", perf_cnt0, 3);
        check_val("perf1_count", perf_cnt1, 2);
        do_reset(1);
        check_val("perf0_cleared", perf_cnt0, 0);
        check_val("perf1_cleared", perf_cnt1, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
